// File: rtl/vfu_pkg.sv
// Shared types and helpers for the parametrised LDPC variable-node update controller.
package vfu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } vfu_state_e;

    localparam int MSG_W_MAX = 8;
    localparam int SUM_W_MAX = MSG_W_MAX + 3;

    // Symmetric clamp to +/-(2^(mw-1)-1); caller keeps the low mw bits.
    function automatic logic [7:0] sat_msg(input logic signed [15:0] x,
                                           input int mw);
        int v;
        int lim;
        v   = int'(x);
        lim = (1 << (mw - 1)) - 1;
        if (v > lim)
            v = lim;
        else if (v < -lim)
            v = -lim;
        return v[7:0];
    endfunction

endpackage

// File: rtl/vfu_ctrl_param_vn_deg.sv
// Combinational min-sum variable-node unit: total sum, per-lane extrinsic
// message with symmetric saturation, and hard decision.
module vn_deg
    import vfu_pkg::*;
#(
    parameter int DEG   = 4,
    parameter int MSG_W = 4
) (
    input  logic [DEG*MSG_W-1:0] i_cn,
    input  logic [MSG_W-1:0]     i_org,
    output logic [DEG*MSG_W-1:0] o_vn,
    output logic                 o_hd
);

    localparam int SUM_W = MSG_W + 3;

    logic signed [SUM_W-1:0] w_ext  [DEG];
    logic signed [SUM_W-1:0] w_diff [DEG];
    logic signed [SUM_W-1:0] w_total;

    for (genvar g = 0; g < DEG; g++) begin : g_lane
        assign w_ext[g]  = {{3{i_cn[g*MSG_W+MSG_W-1]}},
                            i_cn[g*MSG_W +: MSG_W]};
        assign w_diff[g] = w_total - w_ext[g];
        assign o_vn[g*MSG_W +: MSG_W] =
            MSG_W'(sat_msg(16'(w_diff[g]), MSG_W));
    end

    always_comb begin
        w_total = {{3{i_org[MSG_W-1]}}, i_org};
        for (int i = 0; i < DEG; i++)
            w_total = w_total + w_ext[i];
    end

    assign o_hd = w_total[SUM_W-1];

endmodule

// File: rtl/vfu_ctrl_param.sv
// Pipelined VFU controller: one VN read/write per cycle, hard-decision register.
// Define VFU_FLIP_CNT_EN to add the flip_cnt port and its flip counter.
module vfu_ctrl_param
    import vfu_pkg::*;
#(
    parameter int N_VN   = 533,
    parameter int DEG    = 4,
    parameter int MSG_W  = 4,
    parameter int ADDR_W = 10
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic                      flag_VFU_start,
    input  logic                      frame_clr,
    input  logic                      ram_stall,
    input  logic [DEG*MSG_W-1:0]      ram_VFU_data,
    input  logic [MSG_W-1:0]          org_data,
    output logic [ADDR_W-1:0]         VFU_rd_addr,
    output logic                      VFU_re_en,
    output logic [ADDR_W-1:0]         VFU_wr_addr,
    output logic                      VFU_wr_en,
    output logic [DEG*MSG_W-1:0]      VFU_data,
    output logic [N_VN-1:0]           bit_data_reg,
`ifdef VFU_FLIP_CNT_EN
    output logic [$clog2(N_VN+1)-1:0] flip_cnt,
`endif
    output logic                      flag_VFU_end
);

    vfu_state_e          r_state;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_wr_en;
    logic [N_VN-1:0]     r_bit;
    logic [N_VN-1:0]     r_bit_reg;
    logic [N_VN-1:0]     w_bit_next;
    logic [DEG*MSG_W-1:0] w_vn;
    logic                w_hd;
    logic                w_load;

    vn_deg #(
        .DEG   (DEG),
        .MSG_W (MSG_W)
    ) u_vn_deg (
        .i_cn  (ram_VFU_data),
        .i_org (org_data),
        .o_vn  (w_vn),
        .o_hd  (w_hd)
    );

    always_comb begin
        w_bit_next = r_bit;
        if (r_wr_en)
            w_bit_next[r_wr_addr] = w_hd;
    end

    // Result register loads on the DRAIN->DONE edge so it is valid with the end pulse.
    assign w_load = (r_state == DRAIN) && !flag_VFU_start;

    assign VFU_rd_addr  = r_rd_addr;
    assign VFU_re_en    = (r_state == RUN) && !ram_stall;
    assign VFU_wr_addr  = r_wr_addr;
    assign VFU_wr_en    = r_wr_en;
    assign VFU_data     = r_wr_en ? w_vn : '0;
    assign bit_data_reg = r_bit_reg;
    assign flag_VFU_end = (r_state == DONE);

`ifdef VFU_FLIP_CNT_EN
    localparam int CNT_W = $clog2(N_VN + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_flip;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_mis;

    assign w_mis      = r_wr_en && (w_hd != r_bit_reg[r_wr_addr]);
    assign w_cnt_next = r_cnt + CNT_W'(w_mis);
    assign flip_cnt   = r_flip;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt  <= '0;
            r_flip <= '0;
        end else begin
            if (flag_VFU_start)
                r_cnt <= '0;
            else if (r_state == RUN || r_state == DRAIN)
                r_cnt <= w_cnt_next;
            if (w_load)
                r_flip <= w_cnt_next;
            else if (frame_clr)
                r_flip <= '0;
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_en   <= 1'b0;
            r_bit     <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (flag_VFU_start) begin
                r_state   <= RUN;
                r_rd_addr <= '0;
                r_bit     <= '0;
            end else begin
                unique case (r_state)
                    IDLE: ;
                    RUN: begin
                        r_bit <= w_bit_next;
                        if (!ram_stall) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_rd_addr;
                            if (r_rd_addr == ADDR_W'(N_VN - 1)) begin
                                r_state   <= DRAIN;
                                r_rd_addr <= '0;
                            end else begin
                                r_rd_addr <= r_rd_addr + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        r_bit   <= w_bit_next;
                        r_state <= DONE;
                    end
                    DONE: r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_bit_reg <= '0;
        else if (w_load)
            r_bit_reg <= w_bit_next;
        else if (frame_clr)
            r_bit_reg <= '0;
    end

endmodule

// File: tb/tb_vfu_ctrl_param.sv
// Directed bench for vfu_ctrl_param with N_VN=8, DEG=4, MSG_W=4.
module tb_vfu_ctrl_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        fclr = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] ram_data = '0;
    logic [3:0]  org = '0;
    logic [2:0]  rd_addr;
    logic        re_en;
    logic [2:0]  wr_addr;
    logic        wr_en;
    logic [15:0] vfu_data;
    logic [7:0]  bits;
    logic        vend;
`ifdef VFU_FLIP_CNT_EN
    logic [3:0]  flip;
`endif

    logic [15:0] mem_cn  [8];
    logic [3:0]  mem_org [8];
    logic [15:0] exp_vn  [8];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vfu_ctrl_param #(
        .N_VN   (8),
        .DEG    (4),
        .MSG_W  (4),
        .ADDR_W (3)
    ) dut (
        .sys_clk        (clk),
        .sys_rst_n      (rst_n),
        .flag_VFU_start (start),
        .frame_clr      (fclr),
        .ram_stall      (stall),
        .ram_VFU_data   (ram_data),
        .org_data       (org),
        .VFU_rd_addr    (rd_addr),
        .VFU_re_en      (re_en),
        .VFU_wr_addr    (wr_addr),
        .VFU_wr_en      (wr_en),
        .VFU_data       (vfu_data),
        .bit_data_reg   (bits),
`ifdef VFU_FLIP_CNT_EN
        .flip_cnt       (flip),
`endif
        .flag_VFU_end   (vend)
    );

    always @(posedge clk) begin
        if (re_en) begin
            ram_data <= mem_cn[rd_addr];
            org      <= mem_org[rd_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_all(input logic [15:0] cn, input logic [3:0] o,
                           input logic [15:0] vn);
        for (int i = 0; i < 8; i++) begin
            mem_cn[i]  = cn;
            mem_org[i] = o;
            exp_vn[i]  = vn;
        end
    endtask

    task automatic pulse_clr();
        fclr = 1'b1;
        @(posedge clk); #1;
        fclr = 1'b0;
        @(negedge clk);
        chk("clr_bits", 32'(bits), 32'h0);
`ifdef VFU_FLIP_CNT_EN
        chk("clr_flip", 32'(flip), 32'h0);
`endif
        @(posedge clk); #1;
    endtask

    // Called #1 after a rising edge; cycle 0 carries the start pulse.
    task automatic run(input int stall_at, input int stall_len,
                       input int restart_at, input int reset_at,
                       input int exp_end, input logic [7:0] prev_bits,
                       input logic [7:0] exp_bits, input int exp_flip);
        int cyc;
        int wi;
        int ri;
        bit seen;
        cyc = 0; wi = 0; ri = 0; seen = 1'b0;
        while (cyc <= 40 && !seen) begin
            start = (cyc == 0) || (cyc == restart_at);
            stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_wr_en", 32'(wr_en), 32'h0);
                chk("rst_re_en", 32'(re_en), 32'h0);
                chk("rst_end", 32'(vend), 32'h0);
                chk("rst_bits", 32'(bits), 32'h0);
                chk("rst_data", 32'(vfu_data), 32'h0);
                chk("rst_rd_addr", 32'(rd_addr), 32'h0);
`ifdef VFU_FLIP_CNT_EN
                chk("rst_flip", 32'(flip), 32'h0);
`endif
                start = 1'b0;
                stall = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (wr_en) begin
                chk("wr_addr", 32'(wr_addr), 32'(wi));
                chk("vfu_data", 32'(vfu_data), 32'(exp_vn[wi & 7]));
                wi++;
            end
            if (re_en) begin
                chk("rd_addr", 32'(rd_addr), 32'(ri));
                ri++;
            end
            if (stall)
                chk("re_en_stall", 32'(re_en), 32'h0);
            if (cyc == exp_end - 1)
                chk("bits_hold", 32'(bits), 32'(prev_bits));
            if (vend) begin
                chk("end_cycle", 32'(cyc), 32'(exp_end));
                chk("bits", 32'(bits), 32'(exp_bits));
`ifdef VFU_FLIP_CNT_EN
                chk("flip_cnt", 32'(flip), 32'(exp_flip));
`endif
                seen = 1'b1;
            end
            if (cyc == restart_at) begin
                wi = 0;
                ri = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        stall = 1'b0;
        chk("end_seen", 32'(seen), 32'h1);
        chk("wr_count", 32'(wi), 32'h8);
        @(negedge clk);
        chk("end_pulse", 32'(vend), 32'h0);
        chk("bits_keep", 32'(bits), 32'(exp_bits));
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        chk("reset_re_en", 32'(re_en), 32'h0);
        chk("reset_wr_en", 32'(wr_en), 32'h0);
        chk("reset_end", 32'(vend), 32'h0);
        chk("reset_bits", 32'(bits), 32'h0);
        chk("reset_rd_addr", 32'(rd_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // total = 3+1+2-1+0 = 5; lanes 5-cn_i = {4,3,6,5}
        set_all(16'h0F21, 4'h3, 16'h5634);
        run(100, 0, -1, -1, 10, 8'h00, 8'h00, 0);

        set_all(16'h7777, 4'h7, 16'h7777);
        run(100, 0, -1, -1, 10, 8'h00, 8'h00, 0);

        set_all(16'h9999, 4'h9, 16'h9999);
        run(100, 0, -1, -1, 10, 8'h00, 8'hFF, 8);

        pulse_clr();

`ifdef VFU_FLIP_CNT_EN
        // total = -7-4 = -11, lanes -10 -> clamp -7
        set_all(16'hFFFF, 4'h9, 16'h9999);
        run(100, 0, -1, -1, 10, 8'h00, 8'hFF, 8);
        for (int i = 2; i < 8; i += 3) begin
            mem_cn[i]  = 16'h0000;
            mem_org[i] = 4'h7;
            exp_vn[i]  = 16'h7777;
        end
        run(100, 0, -1, -1, 10, 8'hFF, 8'hDB, 2);
        pulse_clr();
`endif

        set_all(16'h9999, 4'h9, 16'h9999);
        run(4, 3, -1, -1, 13, 8'h00, 8'hFF, 8);

        set_all(16'h0F21, 4'h3, 16'h5634);
        run(100, 0, 5, -1, 15, 8'hFF, 8'h00, 8);

        set_all(16'h9999, 4'h9, 16'h9999);
        run(100, 0, -1, -1, 10, 8'h00, 8'hFF, 8);

        set_all(16'h0F21, 4'h3, 16'h5634);
        run(100, 0, -1, 9, 10, 8'hFF, 8'h00, 0);

        run(100, 0, -1, -1, 10, 8'h00, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
